hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: Hazard_Stall_Unit

Interface
REQ-001 SHALL have parameter LOAD_USE_STALLS, default 1, meaning stall cycles for a load followed by a dependent non-branch instruction (legal range 1..3).
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and reset (in, 1, synchronous active-high reset).
REQ-003 SHALL have inputs IFID_Rs (5) and IFID_Rt (5): the source registers of the instruction in ID.
REQ-004 SHALL have inputs IFID_UsesRt (1), meaning the ID instruction reads Rt, and IFID_IsBranch (1), meaning the ID instruction is a branch compared in ID.
REQ-005 SHALL have inputs IDEX_MemRead (1), IDEX_RegWrite (1) and IDEX_WR (5): the EX-stage load flag, write flag and destination.
REQ-006 SHALL have inputs EXMEM_MemRead (1) and EXMEM_WR (5): the MEM-stage load flag and destination.
REQ-007 SHALL have inputs Branch_Taken (1), the ID-stage branch decision, and Mem_Busy (1), meaning data memory is not ready.
REQ-008 SHALL have outputs PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush and Pipe_Freeze, each 1 bit.

Function
REQ-009 "Match(r)" SHALL mean r != 0 and (r == IFID_Rs, or IFID_UsesRt is 1 and r == IFID_Rt).
REQ-010 SHALL have FSM states RUN, STALL and FREEZE, plus a 2-bit remaining-stall counter rem.
REQ-011 Priority each cycle SHALL be: Mem_Busy, then an active stall, then new hazard detection, then Branch_Taken.
REQ-012 Mem_Busy=1 in any state SHALL drive PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0 and Pipe_Freeze=1.
REQ-013 Mem_Busy=1 SHALL move the state to FREEZE, save the prior state, and hold rem unchanged.
REQ-014 On the first cycle after Mem_Busy falls, the FSM SHALL resume in the saved state with rem unchanged.
REQ-015 Load-use hazard in RUN: IDEX_MemRead and Match(IDEX_WR) SHALL give N = LOAD_USE_STALLS, or N = LOAD_USE_STALLS+1 if IFID_IsBranch.
REQ-016 Branch-ALU hazard in RUN: IFID_IsBranch, IDEX_RegWrite, not IDEX_MemRead and Match(IDEX_WR) SHALL give N = 1.
REQ-017 Branch-after-load hazard in RUN: IFID_IsBranch, EXMEM_MemRead and Match(EXMEM_WR) SHALL give N = 1.
REQ-018 If several hazards hit at once, N SHALL be the maximum of their values.
REQ-019 Each stall cycle SHALL drive PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0 and Pipe_Freeze=0.
REQ-020 The detection cycle SHALL be the first stall cycle (Mealy output).
REQ-021 On detection, N=1 SHALL stay in RUN; N>1 SHALL go to STALL with rem=N-1.
REQ-022 In STALL, each non-frozen cycle SHALL be a stall cycle and decrement rem; at rem=1 the next state SHALL be RUN.
REQ-023 Hazard inputs SHALL not be re-evaluated while in STALL.
REQ-024 Branch_Taken SHALL be honored only in a RUN cycle with no Mem_Busy and no hazard.
REQ-025 When honored, Branch_Taken SHALL drive IFID_Flush=1, PC_Write=1 and IFID_Write=1.
REQ-026 A RUN cycle with no event SHALL drive PC_Write=1, IFID_Write=1 and all other outputs 0.

Reset
REQ-027 reset=1 at a clock edge SHALL force state RUN and rem=0, overriding every other input including mid-STALL and mid-FREEZE.
REQ-028 While reset is high, outputs SHALL read PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0 and Pipe_Freeze=0.

Configuration
REQ-029 Macro HAZARD_STATS_EN defined SHALL add output Stall_Count (16), counting cycles with IDEX_Bubble=1.
REQ-030 Stall_Count SHALL saturate at 16'hFFFF and clear to 0 on reset.
REQ-031 Macro HAZARD_STATS_EN undefined SHALL omit the port and the counter, with all other behaviour identical.

Verification
REQ-032 Bench SHALL cover: IDEX_MemRead=1, IDEX_WR=5, IFID_Rs=5, not branch, default parameter -> exactly 1 cycle of IDEX_Bubble=1 and PC_Write=0, then RUN.
REQ-033 Bench SHALL cover: same as REQ-032 with IFID_IsBranch=1 -> 2 consecutive stall cycles, passing through state STALL with rem=1.
REQ-034 Bench SHALL cover: a 2-cycle stall with Mem_Busy=1 for 3 cycles during its second cycle -> 3 cycles of Pipe_Freeze=1, then 1 stall cycle, then RUN.
REQ-035 Bench SHALL cover: Branch_Taken=1 together with a load-use hazard on Rt=7 with IFID_UsesRt=1 -> IFID_Flush=0 and a stall; a later clean cycle with Branch_Taken=1 -> IFID_Flush=1.
REQ-036 Bench SHALL cover: reset asserted during STALL -> RUN next cycle; with HAZARD_STATS_EN defined, Stall_Count=0 after reset and equal to the number of stall cycles after 4 hazards.
REQ-037 Bench SHALL cover: IDEX_WR=0 with IDEX_MemRead=1 and IFID_Rs=0 -> no stall.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Detects load-use and branch-operand hazards for the instruction in ID and
// sequences multi-cycle stalls (bubble into EX, hold PC and IF/ID). A data
// memory busy condition freezes the whole pipe and suspends any stall in
// progress, which then resumes where it left off. A taken branch flushes
// IF/ID only when nothing else is going on.
//
// Optional feature: define HAZARD_STATS_EN to add the 16-bit saturating
// Stall_Count output that counts cycles with IDEX_Bubble=1.
module hazard_stall_unit #(
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IFID_UsesRt,
  input  logic        IFID_IsBranch,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_RegWrite,
  input  logic [4:0]  IDEX_WR,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_WR,
  input  logic        Branch_Taken,
  input  logic        Mem_Busy,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        Pipe_Freeze
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] Stall_Count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // Stall lengths for a load-use hazard; a dependent branch compares in ID,
  // so it needs the loaded value one cycle earlier than an ALU consumer.
  localparam logic [2:0] LUS_N    = 3'(LOAD_USE_STALLS);
  localparam logic [2:0] LUS_BR_N = 3'(LOAD_USE_STALLS + 1);

  // True when producer register r is a real (non-zero) register read by ID.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    logic hit;
    if (r != 5'd0) begin
      hit = (r == rs) || (uses_rt && (r == rt));
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Larger of two stall lengths.
  function automatic logic [2:0] max_len(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

  state_t     r_state;
  state_t     r_saved;
  logic [1:0] r_rem;

  state_t     w_eff_state;
  logic       w_match_ex;
  logic       w_match_mem;
  logic [2:0] w_n_load;
  logic [2:0] w_n_balu;
  logic [2:0] w_n_bload;
  logic [2:0] w_n;

  // Once memory is ready again, a frozen FSM behaves as the state it left.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == ST_FREEZE) begin
      w_eff_state = r_saved;
    end else begin
      w_eff_state = r_state;
    end
  end

  // Hazard detection: required stall length N (0 means no hazard).
  always_comb begin
    w_match_ex  = reg_match(IDEX_WR,  IFID_Rs, IFID_Rt, IFID_UsesRt);
    w_match_mem = reg_match(EXMEM_WR, IFID_Rs, IFID_Rt, IFID_UsesRt);
    w_n_load    = 3'd0;
    w_n_balu    = 3'd0;
    w_n_bload   = 3'd0;

    if (IDEX_MemRead && w_match_ex) begin
      if (IFID_IsBranch) begin
        w_n_load = LUS_BR_N;
      end else begin
        w_n_load = LUS_N;
      end
    end else begin
      w_n_load = 3'd0;
    end

    if (IFID_IsBranch && IDEX_RegWrite && !IDEX_MemRead && w_match_ex) begin
      w_n_balu = 3'd1;
    end else begin
      w_n_balu = 3'd0;
    end

    if (IFID_IsBranch && EXMEM_MemRead && w_match_mem) begin
      w_n_bload = 3'd1;
    end else begin
      w_n_bload = 3'd0;
    end

    w_n = max_len(w_n_load, max_len(w_n_balu, w_n_bload));
  end

  // Pipeline control outputs; Mealy so the detection cycle already stalls.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    Pipe_Freeze = 1'b0;
    if (reset) begin
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
    end else if (Mem_Busy) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if ((w_eff_state == ST_STALL) || (w_n != 3'd0)) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else if (Branch_Taken) begin
      IFID_Flush  = 1'b1;
    end else begin
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
    end
  end

  // Stall/freeze sequencer: freeze suspends, STALL counts down, RUN detects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
      r_rem   <= 2'd0;
    end else if (Mem_Busy) begin
      if (r_state != ST_FREEZE) begin
        r_saved <= r_state;
      end else begin
        r_saved <= r_saved;
      end
      r_state <= ST_FREEZE;
      r_rem   <= r_rem;
    end else if (w_eff_state == ST_STALL) begin
      if (r_rem <= 2'd1) begin
        r_state <= ST_RUN;
        r_rem   <= 2'd0;
      end else begin
        r_state <= ST_STALL;
        r_rem   <= r_rem - 2'd1;
      end
    end else if (w_n > 3'd1) begin
      r_state <= ST_STALL;
      r_rem   <= 2'(w_n - 3'd1);
    end else begin
      r_state <= ST_RUN;
      r_rem   <= r_rem;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_count;

  // Saturating count of bubble cycles since the last reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 16'd0;
    end else if (IDEX_Bubble && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign Stall_Count = r_stall_count;
`endif

endmodule
